// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered round-robin arbiter with optional hold limit.
// Ports: clock, resetn (async, active-low), requests[WIDTH] in;
//   grant_onehot[WIDTH], grant_index[WIDTH_INDEX], grant_valid out.
module round_robin_arbiter #(
  parameter int WIDTH       = 4,
  parameter int WIDTH_INDEX = $clog2(WIDTH),
  parameter int MAX_HOLD    = 0
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [WIDTH-1:0]       requests,
  output logic [WIDTH-1:0]       grant_onehot,
  output logic [WIDTH_INDEX-1:0] grant_index,
  output logic                   grant_valid
);

  localparam int HOLD_W =
    (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t                 state;
  state_t                 nxt_state;
  logic [WIDTH_INDEX-1:0] ptr;
  logic [WIDTH_INDEX-1:0] nxt_ptr;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [HOLD_W-1:0]      nxt_hold;

  logic                   held;
  logic                   others;
  logic                   at_limit;
  logic                   excl;
  logic                   rearb;
  logic                   new_grant;
  logic [WIDTH-1:0]       cand;
  logic [WIDTH-1:0]       rot;
  logic [WIDTH_INDEX-1:0] pos;
  logic [WIDTH_INDEX:0]   sum;
  logic [WIDTH_INDEX-1:0] win_idx;
  logic                   win_found;

  logic [WIDTH-1:0]       nxt_onehot;
  logic [WIDTH_INDEX-1:0] nxt_index;
  logic                   nxt_valid;

  assign held   = |(requests & grant_onehot);
  assign others = |(requests & ~grant_onehot);

  assign at_limit = (MAX_HOLD > 0) &&
                    (int'(hold_cnt) >= MAX_HOLD - 1);

  // Hold limit reached with a competitor waiting: the
  // holder is masked out of this arbitration.
  assign excl = (state == GRANTED) && held &&
                at_limit && others;

  assign rearb = (state == IDLE) || !held || excl;

  assign cand = excl ? (requests & ~grant_onehot)
                     : requests;

  assign new_grant = rearb && win_found;

  // Rotate so the pointer lands on bit 0, pick the lowest
  // set bit, then rotate the position back modulo WIDTH.
  always_comb begin
    rot       = WIDTH'({cand, cand} >> ptr);
    win_found = |rot;
    pos       = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rot[i]) pos = WIDTH_INDEX'(i);
    end
    sum = {1'b0, ptr} + {1'b0, pos};
    if (sum >= (WIDTH_INDEX + 1)'(WIDTH))
      sum = sum - (WIDTH_INDEX + 1)'(WIDTH);
    win_idx = sum[WIDTH_INDEX-1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      ptr          <= '0;
      hold_cnt     <= '0;
      grant_onehot <= '0;
      grant_index  <= '0;
      grant_valid  <= 1'b0;
    end else begin
      state        <= nxt_state;
      ptr          <= nxt_ptr;
      hold_cnt     <= nxt_hold;
      grant_onehot <= nxt_onehot;
      grant_index  <= nxt_index;
      grant_valid  <= nxt_valid;
    end
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE:    if (win_found) nxt_state = GRANTED;
      GRANTED: if (rearb && !win_found) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    nxt_onehot = grant_onehot;
    nxt_index  = grant_index;
    nxt_valid  = grant_valid;
    nxt_ptr    = ptr;
    nxt_hold   = hold_cnt;
    if (new_grant) begin
      nxt_valid  = 1'b1;
      nxt_index  = win_idx;
      nxt_onehot = WIDTH'(1) << win_idx;
      nxt_ptr    = (win_idx == WIDTH_INDEX'(WIDTH - 1))
                 ? '0 : win_idx + 1'b1;
      nxt_hold   = '0;
    end else if (rearb) begin
      nxt_valid  = 1'b0;
      nxt_index  = '0;
      nxt_onehot = '0;
      nxt_hold   = '0;
    end else if (int'(hold_cnt) < MAX_HOLD) begin
      nxt_hold = hold_cnt + 1'b1;
    end
  end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of requesters (2..256, any value, not only powers of two).
REQ-002 SHALL have parameter WIDTH_INDEX, default $clog2(WIDTH), width of the binary grant index.
REQ-003 SHALL have parameter MAX_HOLD, default 0, maximum consecutive cycles one requester keeps the grant while others wait; 0 = unlimited.
REQ-004 SHALL have port clock  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port requests  input  WIDTH  per-requester request level, bit i = requester i.
REQ-007 SHALL have port grant_onehot  output  WIDTH  registered grant, one-hot or all-zero.
REQ-008 SHALL have port grant_index  output  WIDTH_INDEX  registered binary index of the granted requester.
REQ-009 SHALL have port grant_valid  output  1  registered, high when grant_onehot is non-zero.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and GRANTED (one grant held).
REQ-011 SHALL keep a priority pointer (WIDTH_INDEX bits) naming the highest-priority requester for the next arbitration.
REQ-012 SHALL arbitrate by selecting the first set bit of the candidate request vector scanning cyclically from the pointer upward, wrapping from WIDTH-1 to 0.
REQ-013 SHALL register all outputs: a grant decision made from requests in cycle N appears on outputs in cycle N+1.
REQ-014 In IDLE with any request high, SHALL arbitrate over requests and move to GRANTED; with none high, SHALL stay IDLE, outputs zero.
REQ-015 In GRANTED while requests[grant_index] stays high and the hold limit is not reached, SHALL keep grant unchanged.
REQ-016 In GRANTED when requests[grant_index] drops, SHALL re-arbitrate in the same cycle over the remaining requests (no bubble cycle); if none remain, SHALL go to IDLE with outputs cleared next cycle.
REQ-017 On every new grant to index k, SHALL set the pointer to k+1, wrapping to 0 when k = WIDTH-1.
REQ-018 SHALL maintain a hold counter, cleared on every new grant, incremented each cycle the same grant is held, saturating at MAX_HOLD.
REQ-019 When MAX_HOLD > 0, the counter equals MAX_HOLD-1 and any other request is high, SHALL re-arbitrate excluding the current holder, so the holder keeps the grant exactly MAX_HOLD cycles; if no other request is high, SHALL keep the grant.
REQ-020 SHALL guarantee grant_onehot equals 1 << grant_index whenever grant_valid is high, and grant_onehot = 0, grant_index = 0 when grant_valid is low.
REQ-021 SHALL ignore changes on non-granted request bits while a grant is held except for REQ-016/REQ-019 arbitration.
REQ-022 SHALL never grant a requester whose request bit is low in the arbitration cycle.

Reset
REQ-023 On resetn low, SHALL asynchronously clear grant_onehot, grant_index, grant_valid, hold counter, set pointer to 0 and state to IDLE, regardless of state (including mid-grant).
REQ-024 After resetn rises, SHALL arbitrate on the first rising clock edge with resetn high.

Verification
REQ-025 WIDTH=4: reset, then requests=4'b1010 held -> cycle+1 grant_onehot=0010, grant_index=1; drop bit 1 -> next cycle grant_onehot=1000, grant_index=3 with no idle cycle.
REQ-026 WIDTH=4, requests=4'b1111, each granted requester drops its request after 1 cycle held and re-raises it -> grant_index sequence 0,1,2,3,0 (wrap-around fairness).
REQ-027 WIDTH=5 (non power of two): pointer at 4, requests=5'b00011 -> grant_index=0; no index >= 5 ever produced.
REQ-028 WIDTH=4, MAX_HOLD=3: requests=4'b0011 held forever -> grant_index 0 for exactly 3 cycles, then 1 for 3 cycles, alternating; with requests=4'b0001 only -> grant 0 held indefinitely.
REQ-029 Grant held on index 2, resetn pulsed low mid-cycle -> outputs zero immediately without clock edge; after release with requests=4'b0100 -> grant_index=2 one cycle later from pointer 0.
REQ-030 Random requests for 1000+ cycles -> every cycle assert one-hot-or-zero grant_onehot, consistency with grant_index per REQ-020, REQ-022 holds, and no waiting requester starves beyond WIDTH grants (MAX_HOLD>0).
